// File: rtl/edge_det_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   mode_t        - 2-bit per-channel event mode
//   MODE_*        - mode encodings (bit 0 enables rising, bit 1 enables falling)
//   mode_event()  - applies a mode to a pair of accepted-edge strobes
package edge_det_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF  = 2'b00;
  localparam mode_t MODE_RISE = 2'b01;
  localparam mode_t MODE_FALL = 2'b10;
  localparam mode_t MODE_BOTH = 2'b11;

  // The encoding is chosen so each mode bit directly gates one edge
  // direction; MODE_BOTH is simply both gates open.
  function automatic logic mode_event(input mode_t mode,
                                      input logic  rise,
                                      input logic  fall);
    return (rise & mode[0]) | (fall & mode[1]);
  endfunction

endpackage

// File: rtl/edge_det_chan.sv
// One edge-detector channel: synchroniser, glitch filter, edge pulses, mode-gated event, sticky pending.
// Latency: SYNC_STAGES+FILTER_CYCLES-1 edges from the first sampling edge to level/pulse update.
// Backpressure: none; pending holds until write-1-to-clear, a same-cycle new event wins over clear.
//
// Ports:
//   clk, reset     - clock, asynchronous active-low reset
//   a              - asynchronous input line
//   mode           - event mode for this channel (see edge_det_pkg)
//   clear          - write-1-to-clear for pending
//   level          - filtered, synchronised level
//   rise, fall     - one-cycle pulses on accepted edges (not masked by mode)
//   evt            - one-cycle pulse on an accepted edge enabled by mode
//   pending        - sticky event flag
//   pending_next   - next-state of pending, so the parent can register a
//                    summary interrupt in the same cycle as pending itself
module edge_det_chan
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3,
  parameter bit RESET_LEVEL   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a,
  input  logic [1:0] mode,
  input  logic       clear,
  output logic       level,
  output logic       rise,
  output logic       fall,
  output logic       evt,
  output logic       pending,
  output logic       pending_next
);

  localparam int               CNT_W    = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   level_d;
  logic                   accept;
  logic                   acc_rise;
  logic                   acc_fall;
  logic                   evt_d;
  mode_t                  mode_m;

  assign mode_m = mode_t'(mode);

  // ------------------------------------------------------------------
  // Synchroniser: plain shift chain, reset to the idle level so a line
  // that idles high does not look like an edge after reset.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], a};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // ------------------------------------------------------------------
  // Glitch filter. The counter counts cycles that s has disagreed with
  // the accepted level; any agreement restarts the count. The change is
  // accepted on the FILTER_CYCLES-th consecutive disagreeing edge, so a
  // value of 1 accepts on the first edge (no filtering).
  // ------------------------------------------------------------------
  always_comb begin
    cnt_d   = '0;
    level_d = level;
    accept  = 1'b0;
    if (s != level) begin
      // >= rather than == keeps the filter self-recovering should the
      // counter ever hold an out-of-range value.
      if (cnt_q >= CNT_LAST) begin
        accept  = 1'b1;
        level_d = s;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  assign acc_rise = accept &  s;
  assign acc_fall = accept & ~s;

  // Mode is applied at the accepting edge only; a later mode change does
  // not retroactively create or suppress an event.
  assign evt_d        = mode_event(mode_m, acc_rise, acc_fall);
  assign pending_next = (pending & ~clear) | evt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      level   <= RESET_LEVEL;
      rise    <= 1'b0;
      fall    <= 1'b0;
      evt     <= 1'b0;
      pending <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level   <= level_d;
      rise    <= acc_rise;
      fall    <= acc_fall;
      evt     <= evt_d;
      pending <= pending_next;
    end
  end

endmodule

// File: rtl/multi_edge_detector.sv
// N-channel edge detector with per-channel mode masking, sticky pending flags and a summary interrupt.
// Latency: SYNC_STAGES+FILTER_CYCLES-1 edges from first sampling edge to level/pulse/pending/irq.
// Backpressure: none; pending is write-1-to-clear, irq_o follows pending in the same cycle.
//
// Ports:
//   clk             - clock
//   reset           - asynchronous active-low reset
//   a_i[N]          - asynchronous input lines
//   mode_i[2N]      - per-channel mode, channel i at [2i+1:2i]
//   clear_i[N]      - write-1-to-clear for pending_o
//   level_o[N]      - filtered, synchronised levels
//   rising_edge_o   - one-cycle pulses on accepted 0->1 (unmasked)
//   falling_edge_o  - one-cycle pulses on accepted 1->0 (unmasked)
//   event_o[N]      - one-cycle pulses on mode-enabled edges
//   pending_o[N]    - sticky event flags
//   irq_o           - registered OR of pending flags
module multi_edge_detector
  import edge_det_pkg::*;
#(
  parameter int N             = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3,
  parameter bit RESET_LEVEL   = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   a_i,
  input  logic [2*N-1:0] mode_i,
  input  logic [N-1:0]   clear_i,
  output logic [N-1:0]   level_o,
  output logic [N-1:0]   rising_edge_o,
  output logic [N-1:0]   falling_edge_o,
  output logic [N-1:0]   event_o,
  output logic [N-1:0]   pending_o,
  output logic           irq_o
);

  logic [N-1:0] pending_next;

  for (genvar i = 0; i < N; i++) begin : g_chan
    mode_t ch_mode;
    assign ch_mode = mode_i[2*i +: 2];

    edge_det_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .RESET_LEVEL  (RESET_LEVEL)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .a           (a_i[i]),
      .mode        (ch_mode),
      .clear       (clear_i[i]),
      .level       (level_o[i]),
      .rise        (rising_edge_o[i]),
      .fall        (falling_edge_o[i]),
      .evt         (event_o[i]),
      .pending     (pending_o[i]),
      .pending_next(pending_next[i])
    );
  end

  // Registered from the pending next-state rather than from pending_o so
  // the interrupt rises and falls on the same edge as the flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= |pending_next;
    end
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Self-checking bench for multi_edge_detector (N=4, SYNC_STAGES=2, FILTER_CYCLES=3, RESET_LEVEL=0).
// Inputs are driven on the falling edge. A driver issuing input
// a change at the negedge after edge m expects the pulse to be visible
// after edge m+5 (first sampling edge k=m+1, update at k+4).
module tb_multi_edge_detector;

  localparam int N = 4;

  logic           clk;
  logic           reset;
  logic [N-1:0]   a_i;
  logic [2*N-1:0] mode_i;
  logic [N-1:0]   clear_i;
  logic [N-1:0]   level_o;
  logic [N-1:0]   rising_edge_o;
  logic [N-1:0]   falling_edge_o;
  logic [N-1:0]   event_o;
  logic [N-1:0]   pending_o;
  logic           irq_o;

  multi_edge_detector #(
    .N            (N),
    .SYNC_STAGES  (2),
    .FILTER_CYCLES(3),
    .RESET_LEVEL  (1'b0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .a_i           (a_i),
    .mode_i        (mode_i),
    .clear_i       (clear_i),
    .level_o       (level_o),
    .rising_edge_o (rising_edge_o),
    .falling_edge_o(falling_edge_o),
    .event_o       (event_o),
    .pending_o     (pending_o),
    .irq_o         (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int         at;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] evt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, edge_n);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input int at, input logic [3:0] r, input logic [3:0] f,
                          input logic [3:0] e);
    exp_t x;
    x.at = at; x.rise = r; x.fall = f; x.evt = e;
    exp_q.push_back(x);
  endtask

  // Monitor: any pulse on rising/falling/event is a DUT "output" and must
  // match the head of the scoreboard, including the edge it appeared on.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].at < edge_n) begin
      checks++;
      errors++;
      $display("FAIL missing_pulse: got none expected rise=%0h fall=%0h evt=%0h at edge %0d",
               exp_q[0].rise, exp_q[0].fall, exp_q[0].evt, exp_q[0].at);
      void'(exp_q.pop_front());
    end
    if ((rising_edge_o | falling_edge_o | event_o) != 4'h0) begin
      if (exp_q.size() == 0 || exp_q[0].at != edge_n) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got rise=%0h fall=%0h evt=%0h at edge %0d expected none",
                 rising_edge_o, falling_edge_o, event_o, edge_n);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        chk("rising_edge_o", 32'(rising_edge_o), 32'(x.rise));
        chk("falling_edge_o", 32'(falling_edge_o), 32'(x.fall));
        chk("event_o", 32'(event_o), 32'(x.evt));
      end
    end
  end

  initial begin
    int m;
    reset   = 1'b0;
    a_i     = 4'h0;
    clear_i = 4'h0;
    // ch3=11, ch2=00, ch1=11, ch0=01
    mode_i  = 8'b11_00_11_01;

    // Reset state
    tick(2);
    chk("reset_level", 32'(level_o), 32'h0);
    chk("reset_pending", 32'(pending_o), 32'h0);
    chk("reset_irq", 32'(irq_o), 32'h0);
    reset = 1'b1;

    // Idle: no pulses (monitor), nothing pending
    tick(20);
    chk("idle_level", 32'(level_o), 32'h0);
    chk("idle_pending", 32'(pending_o), 32'h0);
    chk("idle_irq", 32'(irq_o), 32'h0);

    // ch0 rise, mode rise
    m = edge_n; a_i[0] = 1'b1;
    push_exp(m + 5, 4'b0001, 4'b0000, 4'b0001);
    tick(4);
    chk("ch0_level_before", 32'(level_o[0]), 32'h0);
    chk("ch0_irq_before", 32'(irq_o), 32'h0);
    tick(1);
    chk("ch0_level", 32'(level_o[0]), 32'h1);
    chk("ch0_pending", 32'(pending_o), 32'h1);
    chk("ch0_irq", 32'(irq_o), 32'h1);
    tick(3);

    // ch1 2-cycle glitch: filtered out
    a_i[1] = 1'b1; tick(2); a_i[1] = 1'b0;
    tick(10);
    chk("ch1_glitch_level", 32'(level_o[1]), 32'h0);
    chk("ch1_glitch_pending", 32'(pending_o[1]), 32'h0);

    // ch1 3-cycle pulse: accepted rise then fall at minimum separation
    m = edge_n; a_i[1] = 1'b1;
    push_exp(m + 5, 4'b0010, 4'b0000, 4'b0010);
    push_exp(m + 8, 4'b0000, 4'b0010, 4'b0010);
    tick(3); a_i[1] = 1'b0;
    tick(8);
    chk("ch1_level", 32'(level_o[1]), 32'h0);
    chk("ch1_pending", 32'(pending_o), 32'h3);

    // ch2 toggles with mode off: raw pulses only
    m = edge_n; a_i[2] = 1'b1;
    push_exp(m + 5, 4'b0100, 4'b0000, 4'b0000);
    tick(6);
    m = edge_n; a_i[2] = 1'b0;
    push_exp(m + 5, 4'b0000, 4'b0100, 4'b0000);
    tick(6);
    chk("ch2_off_pending", 32'(pending_o), 32'h3);

    // ch2 with mode both
    mode_i = 8'b11_11_11_01;
    m = edge_n; a_i[2] = 1'b1;
    push_exp(m + 5, 4'b0100, 4'b0000, 4'b0100);
    tick(6);
    m = edge_n; a_i[2] = 1'b0;
    push_exp(m + 5, 4'b0000, 4'b0100, 4'b0100);
    tick(6);
    chk("ch2_both_pending", 32'(pending_o), 32'h7);

    // Write-1-to-clear
    clear_i = 4'b0001; tick(1); clear_i = 4'b0000;
    chk("clr0_pending", 32'(pending_o), 32'h6);
    chk("clr0_irq", 32'(irq_o), 32'h1);
    clear_i = 4'b1110; tick(1); clear_i = 4'b0000;
    chk("clr_all_pending", 32'(pending_o), 32'h0);
    chk("clr_all_irq", 32'(irq_o), 32'h0);

    // ch0 fall with mode rise: pulse but no event
    m = edge_n; a_i[0] = 1'b0;
    push_exp(m + 5, 4'b0000, 4'b0001, 4'b0000);
    tick(6);
    chk("ch0_fall_pending", 32'(pending_o), 32'h0);
    chk("ch0_fall_irq", 32'(irq_o), 32'h0);

    // ch3: clear in the same cycle as a new event -> set wins
    m = edge_n; a_i[3] = 1'b1;
    push_exp(m + 5, 4'b1000, 4'b0000, 4'b1000);
    tick(4); clear_i = 4'b1000;
    tick(1); clear_i = 4'b0000;
    chk("set_wins_pending", 32'(pending_o), 32'h8);
    chk("set_wins_irq", 32'(irq_o), 32'h1);

    // Mode change does not clear pending
    mode_i = 8'b00_11_11_01;
    tick(2);
    chk("mode_keeps_pending", 32'(pending_o), 32'h8);

    // All lines high
    m = edge_n; a_i = 4'hF;
    push_exp(m + 5, 4'b0111, 4'b0000, 4'b0111);
    tick(6);
    chk("allhigh_level", 32'(level_o), 32'hF);
    chk("allhigh_pending", 32'(pending_o), 32'hF);

    // Mid-run asynchronous reset with inputs held high
    #2 reset = 1'b0;
    #1;
    chk("async_rst_level", 32'(level_o), 32'h0);
    chk("async_rst_pending", 32'(pending_o), 32'h0);
    chk("async_rst_irq", 32'(irq_o), 32'h0);
    tick(3);
    reset = 1'b1;
    m = edge_n;
    push_exp(m + 5, 4'b1111, 4'b0000, 4'b0111);
    tick(4);
    chk("post_rst_level_before", 32'(level_o), 32'h0);
    tick(1);
    chk("post_rst_level", 32'(level_o), 32'hF);
    chk("post_rst_pending", 32'(pending_o), 32'h7);
    chk("post_rst_irq", 32'(irq_o), 32'h1);

    tick(5);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
